xsw_ingress_fifo: RTL and testbench
===================================

# xsw_ingress_fifo

Per-input ingress buffer that sits directly upstream of the N×M crossbar switch: one instance per switch input port. It accepts (data, destination index) beats from a source over a vld/gnt handshake and stores them in a FIFO. It presents the head beat to the switch as vld plus DW data plus a one-hot M-bit route vector (the switch's per-input sw slice). Beats with out-of-range destinations are absorbed and counted, never forwarded.

## Interface
- DW, 8, data width per beat
- M, 2, number of switch outputs (≥2); width of the one-hot route vector
- DEPTH, 4, FIFO entries; power of two, ≥2
- DSTW, $clog2(M), destination index width (derived, not overridden)
- CW, $clog2(DEPTH)+1, occupancy count width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- vld_i  in  1  source beat valid
- dat_i  in  DW  source data
- dst_i  in  DSTW  destination output index
- gnt_i  out  1  acceptance to source
- vld_o  out  1  head beat valid toward switch
- dat_o  out  DW  head data
- sw_o  out  M  one-hot route of head beat
- gnt_o  in  1  switch accepts head beat (|(gnt & sw) from switch)
- count_o  out  CW  current occupancy
- drop_cnt_o  out  8  saturating count of dropped beats

## Operation
- Handshake on both sides: a transfer occurs in a cycle where vld and gnt are both high at the rising edge. The source must hold vld_i/dat_i/dst_i stable until granted. The switch side follows the same rule.
- gnt_i = !full. It is independent of vld_i, so there is no combinational path from gnt_o to gnt_i.
- Push: vld_i & gnt_i & (dst_i < M). This writes {dat_i, dst_i} at wr_ptr, and wr_ptr increments modulo DEPTH.
- Drop: vld_i & gnt_i & (dst_i ≥ M). The beat is consumed and not stored. drop_cnt_o increments and saturates at 255. This only arises when M is not a power of two.
- Pop: vld_o & gnt_o. rd_ptr increments modulo DEPTH.
- vld_o = !empty. dat_o is the head data when not empty and 0 when empty.
- sw_o: bit k is 1 iff the head's dst == k and the FIFO is not empty. It is all-zero when empty.
- count tracks occupancy:
  - push only: count + 1
  - pop only: count − 1
  - push and pop in the same cycle: count unchanged
- full = (count == DEPTH); empty = (count == 0).
- Pointers are DSTW-independent, log2(DEPTH) bits wide, and wrap naturally.
- Storage may be flops or a register array. No output register stage: outputs are decoded from the head entry and count.

## Timing
- Reset (async assert, sync-safe deassert): count_o = 0, both pointers = 0, drop_cnt_o = 0. Therefore vld_o = 0, dat_o = 0, sw_o = 0, and gnt_i = 1 immediately on the first cycle after reset.
- Latency: a beat pushed at edge t into an empty FIFO gives vld_o = 1 with its data and route in the cycle after edge t. There is no same-cycle fall-through.
- Full FIFO with a simultaneous pop: gnt_i stays 0 that cycle. The freed slot is visible as gnt_i = 1 in the following cycle.
- Empty FIFO with a simultaneous push: no pop is possible (vld_o = 0). The beat becomes the head next cycle.
- Full FIFO with vld_i held high: the source is back-pressured indefinitely and no data is lost.
- A drop while the FIFO is full cannot occur, because gnt_i = 0 gates it.
- Reset mid-operation: all stored beats are discarded. Outputs return to their reset values asynchronously on rst assertion.
- Steady state: one push and one pop per cycle with gnt_o held high and a non-empty FIFO gives 100% throughput.

## Test plan
- Reset, then fill: DW=8, M=4, DEPTH=4, gnt_o=0. Push dat 0x11..0x44 with dst 0..3. Required: gnt_i drops to 0 after the 4th push, count_o=4, vld_o=1, dat_o=0x11, sw_o=4'b0001.
- Drain in order: continuing from the previous case, hold gnt_o=1. Required: dat_o sequence 0x11, 0x22, 0x33, 0x44 with sw_o 0001, 0010, 0100, 1000 on consecutive cycles. Then vld_o=0, sw_o=0, dat_o=0, count_o=0.
- Streaming with wrap-around: 20 beats with continuous vld_i and gnt_o=1. Required: count_o ≤ 1, one beat per cycle after the first, output order equals input order across pointer wrap.
- Full with simultaneous pop: FIFO full, gnt_o=1 and vld_i=1 in the same cycle. Required: gnt_i=0 that cycle, count_o=3 next cycle, gnt_i=1 next cycle.
- Drop path: M=3, dst_i=3 with vld_i=1 for 300 beats. Required: gnt_i=1, count_o stays 0, vld_o stays 0, drop_cnt_o saturates at 255.
- Async reset mid-stream: rst asserted between edges while count_o=3. Required: vld_o, sw_o, dat_o and count_o go to 0 without a clock edge, and gnt_i=1 after release.

Source files
------------

// File: rtl/xsw_ingress_fifo_if.sv
// Source-side and switch-side signals of one crossbar ingress buffer.
// slave = the FIFO, master = whatever drives the source and switch sides.
interface xsw_ingress_fifo_if #(
  parameter int DW    = 8,
  parameter int M     = 2,
  parameter int DEPTH = 4
);
  localparam int DSTW = $clog2(M);
  localparam int CW   = $clog2(DEPTH) + 1;

  logic            vld_i;
  logic [DW-1:0]   dat_i;
  logic [DSTW-1:0] dst_i;
  logic            gnt_i;
  logic            vld_o;
  logic [DW-1:0]   dat_o;
  logic [M-1:0]    sw_o;
  logic            gnt_o;
  logic [CW-1:0]   count_o;
  logic [7:0]      drop_cnt_o;

  modport slave (
    input  vld_i, dat_i, dst_i, gnt_o,
    output gnt_i, vld_o, dat_o, sw_o, count_o, drop_cnt_o
  );

  modport master (
    output vld_i, dat_i, dst_i, gnt_o,
    input  gnt_i, vld_o, dat_o, sw_o, count_o, drop_cnt_o
  );
endinterface

// File: rtl/xsw_ingress_fifo.sv
// Per-input crossbar ingress FIFO: buffers (data, dst) beats and presents the
// head as vld + data + one-hot route; out-of-range destinations are dropped and counted.
module xsw_ingress_fifo #(
  parameter int DW    = 8,
  parameter int M     = 2,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  xsw_ingress_fifo_if.slave  bus
);
  localparam int DSTW = $clog2(M);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  logic [DW-1:0]   dat_mem_q [DEPTH];
  logic [DSTW-1:0] dst_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;

  logic full, empty, in_range, acc, push, drop, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_range = (int'(bus.dst_i) < M);
  // gnt_i depends only on state, so no gnt_o -> gnt_i path exists
  assign acc      = bus.vld_i & ~full;
  assign push     = acc & in_range;
  assign drop     = acc & ~in_range;
  assign pop      = ~empty & bus.gnt_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: every read of it is masked by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      dat_mem_q[wr_ptr_q] <= bus.dat_i;
      dst_mem_q[wr_ptr_q] <= bus.dst_i;
    end
  end

  always_comb begin
    bus.sw_o = '0;
    for (int k = 0; k < M; k++)
      bus.sw_o[k] = ~empty && (dst_mem_q[rd_ptr_q] == DSTW'(k));
  end

  assign bus.gnt_i      = ~full;
  assign bus.vld_o      = ~empty;
  assign bus.dat_o      = empty ? '0 : dat_mem_q[rd_ptr_q];
  assign bus.count_o    = count_q;
  assign bus.drop_cnt_o = drop_q;
endmodule

// File: tb/tb_xsw_ingress_fifo.sv
// Directed bench: table-driven fill/drain on an M=4 instance plus hand-written
// sequences for streaming, full+pop, async reset and the M=3 drop path.
module tb_xsw_ingress_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xsw_ingress_fifo_if #(.DW(8), .M(4), .DEPTH(4)) ifa ();
  xsw_ingress_fifo_if #(.DW(8), .M(3), .DEPTH(4)) ifb ();

  xsw_ingress_fifo #(.DW(8), .M(4), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  xsw_ingress_fifo #(.DW(8), .M(3), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic [1:0] ds, input logic g);
    ifa.vld_i = v; ifa.dat_i = d; ifa.dst_i = ds; ifa.gnt_o = g;
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic [1:0] dst;
    logic       gnt;
    logic       e_gnt_i;
    logic       e_vld;
    logic [7:0] e_dat;
    logic [3:0] e_sw;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // fill with gnt_o=0, then drain in order
    tbl[0] = '{1'b1, 8'h11, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd0};
    tbl[1] = '{1'b1, 8'h22, 2'd1, 1'b0, 1'b1, 1'b1, 8'h11, 4'b0001, 3'd1};
    tbl[2] = '{1'b1, 8'h33, 2'd2, 1'b0, 1'b1, 1'b1, 8'h11, 4'b0001, 3'd2};
    tbl[3] = '{1'b1, 8'h44, 2'd3, 1'b0, 1'b1, 1'b1, 8'h11, 4'b0001, 3'd3};
    tbl[4] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 4'b0001, 3'd4};
    tbl[5] = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 8'h11, 4'b0001, 3'd4};
    tbl[6] = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, 8'h22, 4'b0010, 3'd3};
    tbl[7] = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, 8'h33, 4'b0100, 3'd2};
    tbl[8] = '{1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, 8'h44, 4'b1000, 3'd1};
    tbl[9] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd0};

    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    ifb.vld_i = 1'b0; ifb.dat_i = '0; ifb.dst_i = '0; ifb.gnt_o = 1'b0;
    #12 rst = 1'b0;
    step();

    chk("rst_count", 32'(ifa.count_o), 32'd0);
    chk("rst_vld",   32'(ifa.vld_o),   32'd0);
    chk("rst_dat",   32'(ifa.dat_o),   32'd0);
    chk("rst_sw",    32'(ifa.sw_o),    32'd0);
    chk("rst_gnt_i", 32'(ifa.gnt_i),   32'd1);
    chk("rst_drop",  32'(ifb.drop_cnt_o), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive_a(tbl[i].vld, tbl[i].dat, tbl[i].dst, tbl[i].gnt);
      #1;
      chk($sformatf("tbl%0d_gnt_i", i), 32'(ifa.gnt_i),   32'(tbl[i].e_gnt_i));
      chk($sformatf("tbl%0d_vld",   i), 32'(ifa.vld_o),   32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_dat",   i), 32'(ifa.dat_o),   32'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_sw",    i), 32'(ifa.sw_o),    32'(tbl[i].e_sw));
      chk($sformatf("tbl%0d_count", i), 32'(ifa.count_o), 32'(tbl[i].e_cnt));
      step();
    end

    // streaming across pointer wrap: beat i carries data i+1, dst i%4
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) drive_a(1'b1, 8'(i + 1), 2'(i % 4), 1'b1);
      else        drive_a(1'b0, 8'h00, 2'd0, 1'b1);
      #1;
      chk($sformatf("strm%0d_cnt_le1", i), 32'(ifa.count_o <= 3'd1), 32'd1);
      if (i > 0) begin
        chk($sformatf("strm%0d_vld", i), 32'(ifa.vld_o), 32'd1);
        chk($sformatf("strm%0d_dat", i), 32'(ifa.dat_o), 32'(i));
        chk($sformatf("strm%0d_sw",  i), 32'(ifa.sw_o),  32'(4'b0001 << ((i - 1) % 4)));
      end
      step();
    end
    chk("strm_end_count", 32'(ifa.count_o), 32'd0);

    // full with a simultaneous pop and a waiting source beat
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 8'hA1 + 8'(i), 2'(i), 1'b0);
      step();
    end
    drive_a(1'b1, 8'h55, 2'd1, 1'b1);
    #1;
    chk("fp_gnt_i_full", 32'(ifa.gnt_i),   32'd0);
    chk("fp_count_full", 32'(ifa.count_o), 32'd4);
    chk("fp_head",       32'(ifa.dat_o),   32'hA1);
    step();
    chk("fp_count_next", 32'(ifa.count_o), 32'd3);
    chk("fp_gnt_i_next", 32'(ifa.gnt_i),   32'd1);
    chk("fp_head_next",  32'(ifa.dat_o),   32'hA2);
    ifa.gnt_o = 1'b0;
    step();
    chk("fp_count_refill", 32'(ifa.count_o), 32'd4);
    drive_a(1'b0, 8'h00, 2'd0, 1'b1);
    begin
      logic [7:0] ed[4];
      logic [3:0] es[4];
      ed = '{8'hA2, 8'hA3, 8'hA4, 8'h55};
      es = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
      for (int i = 0; i < 4; i++) begin
        #1;
        chk($sformatf("fp_drain%0d_dat", i), 32'(ifa.dat_o), 32'(ed[i]));
        chk($sformatf("fp_drain%0d_sw",  i), 32'(ifa.sw_o),  32'(es[i]));
        step();
      end
    end
    chk("fp_empty_vld", 32'(ifa.vld_o), 32'd0);

    // async reset with three beats stored
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 8'hC0 + 8'(i), 2'(i), 1'b0);
      step();
    end
    drive_a(1'b0, 8'h00, 2'd0, 1'b0);
    chk("ar_count_pre", 32'(ifa.count_o), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar_vld",   32'(ifa.vld_o),   32'd0);
    chk("ar_sw",    32'(ifa.sw_o),    32'd0);
    chk("ar_dat",   32'(ifa.dat_o),   32'd0);
    chk("ar_count", 32'(ifa.count_o), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("ar_gnt_i_after", 32'(ifa.gnt_i),   32'd1);
    chk("ar_count_after", 32'(ifa.count_o), 32'd0);

    // drop path on M=3: dst 3 is out of range
    ifb.vld_i = 1'b1; ifb.dat_i = 8'hEE; ifb.dst_i = 2'd3; ifb.gnt_o = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      chk($sformatf("drop%0d_gnt_i", i), 32'(ifb.gnt_i),   32'd1);
      chk($sformatf("drop%0d_count", i), 32'(ifb.count_o), 32'd0);
      chk($sformatf("drop%0d_vld",   i), 32'(ifb.vld_o),   32'd0);
      if (i == 10) chk("drop_cnt_10", 32'(ifb.drop_cnt_o), 32'd10);
      step();
    end
    ifb.vld_i = 1'b0;
    #1;
    chk("drop_cnt_sat", 32'(ifb.drop_cnt_o), 32'd255);
    ifb.vld_i = 1'b1; ifb.dat_i = 8'h5A; ifb.dst_i = 2'd2;
    step();
    ifb.vld_i = 1'b0;
    #1;
    chk("b_push_vld", 32'(ifb.vld_o),      32'd1);
    chk("b_push_dat", 32'(ifb.dat_o),      32'h5A);
    chk("b_push_sw",  32'(ifb.sw_o),       32'b100);
    chk("b_drop_hold", 32'(ifb.drop_cnt_o), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
